// File: rtl/nq_pkg.sv
// Shared encodings for the NanoQuarter execute/memory/write-back slice.
package nq_pkg;

   // Major opcode classes carried in op_in
   typedef enum logic [1:0] {
      OP_R   = 2'b00,
      OP_MEM = 2'b01,
      OP_BR  = 2'b10,
      OP_JMP = 2'b11
   } op_e;

   // ALU function codes
   typedef enum logic [2:0] {
      F_NAND = 3'b000,
      F_XOR  = 3'b001,
      F_SLL  = 3'b010,
      F_SRL  = 3'b011,
      F_SRA  = 3'b100,
      F_ADD  = 3'b101,
      F_SUB  = 3'b110,
      F_PASS = 3'b111
   } alu_fn_e;

   // Memory sub-operations, taken from funct_in[1:0]
   typedef enum logic [1:0] {
      M_LW = 2'b00,
      M_SW = 2'b01,
      M_LB = 2'b10,
      M_SB = 2'b11
   } mem_op_e;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned PC_W   = 32;

endpackage

// File: rtl/nq_alu.sv
// 16-bit combinational ALU: logic, shifts and add/sub, no flags.
module nq_alu
   import nq_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [2:0]        op_i,
   input  logic [1:0]        shamt_i,
   output logic [DATA_W-1:0] result_o
);

   alu_fn_e fn;
   assign fn = alu_fn_e'(op_i);

   // Evaluate the selected function; arithmetic wraps at 16 bits
   always_comb begin
      result_o = '0;
      case (fn)
         F_NAND:  result_o = ~(a_i & b_i);
         F_XOR:   result_o = a_i ^ b_i;
         F_SLL:   result_o = a_i << shamt_i;
         F_SRL:   result_o = a_i >> shamt_i;
         F_SRA:   result_o = $unsigned($signed(a_i) >>> shamt_i);
         F_ADD:   result_o = a_i + b_i;
         F_SUB:   result_o = a_i - b_i;
         F_PASS:  result_o = b_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/integration_2.sv
// NanoQuarter execute/memory/write-back slice: ALU, write-back mux,
// register-write decode and the registered next-PC.
module integration_2
   import nq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] reg1data_in,
   input  logic [15:0] reg2data_in,
   input  logic [7:0]  jtarget_in,
   input  logic [5:0]  memaddr_in,
   input  logic [4:0]  boffset_in,
   input  logic [2:0]  funct_in,
   input  logic [2:0]  ALUfunct_in,
   input  logic [1:0]  op_in,
   input  logic [1:0]  shamt_in,
   input  logic        bne_in,
   input  logic        jr_in,
   input  logic [31:0] PC_in,
   input  logic [15:0] memdata,
   output logic [31:0] PC_out,
   output logic [15:0] mmuxout,
   output logic        regwrite
);

   op_e         op;
   mem_op_e     mem_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_res;
   logic [31:0] pc_inc;
   logic [31:0] boff_ext;
   logic [31:0] pc_d;
   logic [31:0] pc_q;

   assign op     = op_e'(op_in);
   assign mem_op = mem_op_e'(funct_in[1:0]);

   // Operand/function select; memory ops force base+offset address generation
   always_comb begin
      alu_a  = reg1data_in;
      alu_b  = reg2data_in;
      alu_op = (op == OP_R) ? funct_in : ALUfunct_in;
      if (op == OP_MEM) begin
         alu_a  = reg2data_in;
         alu_b  = {10'b0, memaddr_in};
         alu_op = F_ADD;
      end
   end

   nq_alu u_alu (
      .a_i      (alu_a),
      .b_i      (alu_b),
      .op_i     (alu_op),
      .shamt_i  (shamt_in),
      .result_o (alu_res)
   );

   // Write-back data: loads return memory data, everything else the ALU result
   always_comb begin
      mmuxout = alu_res;
      if (op == OP_MEM) begin
         case (mem_op)
            M_LW:    mmuxout = memdata;
            M_LB:    mmuxout = {{8{memdata[7]}}, memdata[7:0]};
            default: mmuxout = alu_res;
         endcase
      end
   end

   // Register write for R-type and loads only
   always_comb begin
      regwrite = 1'b0;
      case (op)
         OP_R:    regwrite = 1'b1;
         OP_MEM:  regwrite = (mem_op == M_LW) || (mem_op == M_LB);
         default: regwrite = 1'b0;
      endcase
   end

   assign pc_inc   = PC_in + 32'd1;
   assign boff_ext = {{27{boffset_in[4]}}, boffset_in};

   // Next-PC priority: jump, taken BNE, then sequential
   always_comb begin
      if (jr_in)
         pc_d = {24'b0, jtarget_in};
      else if (bne_in && (reg1data_in != reg2data_in))
         pc_d = pc_inc + boff_ext;
      else
         pc_d = pc_inc;
   end

   // PC register, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_q <= '0;
      else
         pc_q <= pc_d;
   end

   assign PC_out = pc_q;

endmodule

// File: tb/tb_integration_2.sv
// Directed self-checking bench for integration_2.
module tb_integration_2;

   logic        clk;
   logic        rst;
   logic [15:0] reg1data_in;
   logic [15:0] reg2data_in;
   logic [7:0]  jtarget_in;
   logic [5:0]  memaddr_in;
   logic [4:0]  boffset_in;
   logic [2:0]  funct_in;
   logic [2:0]  ALUfunct_in;
   logic [1:0]  op_in;
   logic [1:0]  shamt_in;
   logic        bne_in;
   logic        jr_in;
   logic [31:0] PC_in;
   logic [15:0] memdata;
   logic [31:0] PC_out;
   logic [15:0] mmuxout;
   logic        regwrite;

   int errors = 0;
   int checks = 0;

   integration_2 dut (
      .clk         (clk),
      .rst         (rst),
      .reg1data_in (reg1data_in),
      .reg2data_in (reg2data_in),
      .jtarget_in  (jtarget_in),
      .memaddr_in  (memaddr_in),
      .boffset_in  (boffset_in),
      .funct_in    (funct_in),
      .ALUfunct_in (ALUfunct_in),
      .op_in       (op_in),
      .shamt_in    (shamt_in),
      .bne_in      (bne_in),
      .jr_in       (jr_in),
      .PC_in       (PC_in),
      .memdata     (memdata),
      .PC_out      (PC_out),
      .mmuxout     (mmuxout),
      .regwrite    (regwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then sample 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if (PC_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_pc got=%h exp=%h", PC_out, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_alu_rtype();
      logic [2:0]  fn  [4] = '{3'b000, 3'b001, 3'b101, 3'b110};
      logic [15:0] exp [4] = '{16'hFFFF, 16'h0FFF, 16'h0FFF, 16'hF1E1};
      op_in = 2'b00; reg1data_in = 16'h00F0; reg2data_in = 16'h0F0F;
      ALUfunct_in = 3'b111;
      for (int i = 0; i < 4; i++) begin
         funct_in = fn[i];
         #1;
         checks++;
         if (mmuxout !== exp[i]) begin
            errors++;
            $display("FAIL alu_f%0d got=%h exp=%h", fn[i], mmuxout, exp[i]);
         end
         checks++;
         if (regwrite !== 1'b1) begin
            errors++;
            $display("FAIL alu_regwrite_f%0d got=%b exp=1", fn[i], regwrite);
         end
      end
   endtask

   task automatic test_shift();
      op_in = 2'b00; reg1data_in = 16'h8000; reg2data_in = 16'h1234; shamt_in = 2'd3;
      funct_in = 3'b011; #1;
      checks++;
      if (mmuxout !== 16'h1000) begin
         errors++; $display("FAIL srl got=%h exp=%h", mmuxout, 16'h1000);
      end
      funct_in = 3'b100; #1;
      checks++;
      if (mmuxout !== 16'hF000) begin
         errors++; $display("FAIL sra got=%h exp=%h", mmuxout, 16'hF000);
      end
      reg1data_in = 16'h00F0; shamt_in = 2'd2; funct_in = 3'b010; #1;
      checks++;
      if (mmuxout !== 16'h03C0) begin
         errors++; $display("FAIL sll got=%h exp=%h", mmuxout, 16'h03C0);
      end
   endtask

   task automatic test_nonr_select();
      // Branch class uses ALUfunct_in, not funct_in; regwrite must be 0
      op_in = 2'b10; reg1data_in = 16'h00F0; reg2data_in = 16'h0F0F;
      funct_in = 3'b000; ALUfunct_in = 3'b110; #1;
      checks++;
      if (mmuxout !== 16'hF1E1) begin
         errors++; $display("FAIL aluf_sel got=%h exp=%h", mmuxout, 16'hF1E1);
      end
      checks++;
      if (regwrite !== 1'b0) begin
         errors++; $display("FAIL br_regwrite got=%b exp=0", regwrite);
      end
   endtask

   task automatic test_mem();
      logic [1:0]  sub [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
      logic [15:0] exp [4] = '{16'h1280, 16'hFF80, 16'h0025, 16'h0025};
      logic        wr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      op_in = 2'b01; reg1data_in = 16'hAAAA; reg2data_in = 16'h0010;
      memaddr_in = 6'h15; memdata = 16'h1280; ALUfunct_in = 3'b000;
      for (int i = 0; i < 4; i++) begin
         funct_in = {1'b0, sub[i]};
         #1;
         checks++;
         if (mmuxout !== exp[i]) begin
            errors++; $display("FAIL mem_%0d_data got=%h exp=%h", sub[i], mmuxout, exp[i]);
         end
         checks++;
         if (regwrite !== wr[i]) begin
            errors++; $display("FAIL mem_%0d_regwrite got=%b exp=%b", sub[i], regwrite, wr[i]);
         end
      end
   endtask

   task automatic test_pc_seq_and_async_reset();
      @(negedge clk);
      op_in = 2'b00; bne_in = 1'b0; jr_in = 1'b0;
      jtarget_in = 8'hxx; boffset_in = 5'bxxxxx;
      PC_in = 32'h10;
      tick();
      checks++;
      if (PC_out !== 32'h11) begin
         errors++; $display("FAIL pc_seq got=%h exp=%h", PC_out, 32'h11);
      end
      // Reset mid-cycle clears immediately and holds through an edge
      #2 rst = 1'b1;
      #1;
      checks++;
      if (PC_out !== 32'h0) begin
         errors++; $display("FAIL pc_async_rst got=%h exp=%h", PC_out, 32'h0);
      end
      PC_in = 32'h40;
      tick();
      checks++;
      if (PC_out !== 32'h0) begin
         errors++; $display("FAIL pc_rst_hold got=%h exp=%h", PC_out, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++;
      if (PC_out !== 32'h41) begin
         errors++; $display("FAIL pc_after_rst got=%h exp=%h", PC_out, 32'h41);
      end
   endtask

   task automatic test_branch();
      @(negedge clk);
      op_in = 2'b10; jr_in = 1'b0; bne_in = 1'b1; jtarget_in = 8'hxx;
      PC_in = 32'h20; boffset_in = 5'h0E;
      reg1data_in = 16'h0001; reg2data_in = 16'h0002;
      tick();
      checks++;
      if (PC_out !== 32'h2F) begin
         errors++; $display("FAIL bne_taken got=%h exp=%h", PC_out, 32'h2F);
      end
      @(negedge clk);
      reg2data_in = 16'h0001;
      tick();
      checks++;
      if (PC_out !== 32'h21) begin
         errors++; $display("FAIL bne_equal got=%h exp=%h", PC_out, 32'h21);
      end
      @(negedge clk);
      reg2data_in = 16'h0002; boffset_in = 5'h1F;
      tick();
      checks++;
      if (PC_out !== 32'h20) begin
         errors++; $display("FAIL bne_neg got=%h exp=%h", PC_out, 32'h20);
      end
      // Wrap across 32-bit boundary: 0xFFFFFFFF + 1 + 0 -> 0
      @(negedge clk);
      bne_in = 1'b0; boffset_in = 5'bxxxxx; PC_in = 32'hFFFF_FFFF;
      tick();
      checks++;
      if (PC_out !== 32'h0) begin
         errors++; $display("FAIL pc_wrap got=%h exp=%h", PC_out, 32'h0);
      end
   endtask

   task automatic test_jump();
      @(negedge clk);
      op_in = 2'b11; jr_in = 1'b1; bne_in = 1'b1; jtarget_in = 8'h05;
      boffset_in = 5'h0E; PC_in = 32'h20;
      reg1data_in = 16'h0001; reg2data_in = 16'h0002;
      #1;
      checks++;
      if (regwrite !== 1'b0) begin
         errors++; $display("FAIL jmp_regwrite got=%b exp=0", regwrite);
      end
      tick();
      checks++;
      if (PC_out !== 32'h05) begin
         errors++; $display("FAIL jmp_pc got=%h exp=%h", PC_out, 32'h05);
      end
      @(negedge clk);
      jtarget_in = 8'hF0;
      tick();
      checks++;
      if (PC_out !== 32'h0000_00F0) begin
         errors++; $display("FAIL jmp_zext got=%h exp=%h", PC_out, 32'h0000_00F0);
      end
   endtask

   initial begin
      rst = 1'b0;
      reg1data_in = '0; reg2data_in = '0; jtarget_in = '0; memaddr_in = '0;
      boffset_in = '0; funct_in = '0; ALUfunct_in = '0; op_in = '0;
      shamt_in = '0; bne_in = 1'b0; jr_in = 1'b0; PC_in = '0; memdata = '0;
      #3;
      test_reset();
      test_alu_rtype();
      test_shift();
      test_nonr_select();
      test_mem();
      test_pc_seq_and_async_reset();
      test_branch();
      test_jump();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
